button_conditioner: RTL

Input conditioning stage between the raw player push-buttons and the game top level. Each of the two channels (left, right) is synchronised into the `clk` domain, debounced with a counter filter, and converted into a single-cycle press pulse that drives the `pbl`/`pbr` inputs of the game. A debounced level and a stuck-button flag are also provided per channel for diagnostics and round gating.

---
 rtl/button_conditioner.sv | 124 ++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner
// ------------------
// Conditions the two raw player push-buttons for the game top level.
// Each channel does the following, independently of the other:
//   - a two-flop synchroniser brings the raw input into the clk domain;
//   - a symmetric counter filter debounces it into a stable level;
//   - a registered one-cycle pulse marks each debounced press;
//   - a saturating hold counter raises a stuck flag on long holds.
// Nothing is arbitrated between left and right, so a simultaneous press
// gives simultaneous pulses.
//
// Parameters
//   DB_COUNT    : consecutive differing samples needed to flip the level
//   STUCK_COUNT : cycles of stable-high before the stuck flag sets
//   CNT_W       : width of the debounce counter
//   STK_W       : width of the hold counter
//
// Ports
//   clk        in  : system clock, rising edge
//   rst        in  : asynchronous reset, active-low
//   pbl_raw    in  : raw left button (async, active-high, bouncy)
//   pbr_raw    in  : raw right button
//   pbl / pbr  out : one-cycle pulse per debounced press
//   pbl_level  out : debounced left level
//   pbr_level  out : debounced right level
//   stuck_l    out : left held for at least STUCK_COUNT cycles
//   stuck_r    out : right held for at least STUCK_COUNT cycles
module button_conditioner #(
    parameter int DB_COUNT    = 50000,
    parameter int STUCK_COUNT = 2000000,
    parameter int CNT_W       = 16,
    parameter int STK_W       = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic pbl_raw,
    input  logic pbr_raw,
    output logic pbl,
    output logic pbr,
    output logic pbl_level,
    output logic pbr_level,
    output logic stuck_l,
    output logic stuck_r
);

    // Terminal value of the debounce counter and saturation value of the
    // hold counter, sized to the counters they are compared with.
    localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DB_COUNT - 1);
    localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_COUNT);

    // Bit 0 is the left channel, bit 1 the right channel.
    logic [1:0] raw_bus;
    logic [1:0] pulse_bus;
    logic [1:0] level_bus;
    logic [1:0] stuck_bus;

    assign raw_bus = {pbr_raw, pbl_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic             s1_reg;
            logic             s2_reg;
            logic             lvl_reg;
            logic             pulse_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic [STK_W-1:0] hold_reg;
            logic             rise_next;

            // The level is about to flip 0 -> 1 on this edge: the pulse is
            // registered on the very same edge as the level, so the two rise
            // together and the pulse lasts exactly one cycle.
            assign rise_next = s2_reg & ~lvl_reg & (cnt_reg == DB_TERM);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_reg    <= 1'b0;
                    s2_reg    <= 1'b0;
                    lvl_reg   <= 1'b0;
                    pulse_reg <= 1'b0;
                    cnt_reg   <= '0;
                    hold_reg  <= '0;
                end else begin
                    s1_reg <= raw_bus[gi];
                    s2_reg <= s1_reg;

                    // Counter filter: any sample agreeing with the stable
                    // level restarts the count, so only an unbroken run of
                    // DB_COUNT differing samples flips the level.
                    if (s2_reg == lvl_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_TERM) begin
                        lvl_reg <= s2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end

                    pulse_reg <= rise_next;

                    // Hold counter follows the registered level, so the
                    // stuck flag lingers for the one cycle after a release.
                    if (!lvl_reg) begin
                        hold_reg <= '0;
                    end else if (hold_reg != STK_MAX) begin
                        hold_reg <= hold_reg + STK_W'(1);
                    end
                end
            end

            assign pulse_bus[gi] = pulse_reg;
            assign level_bus[gi] = lvl_reg;
            assign stuck_bus[gi] = (hold_reg == STK_MAX);
        end
    endgenerate

    assign pbl       = pulse_bus[0];
    assign pbr       = pulse_bus[1];
    assign pbl_level = level_bus[0];
    assign pbr_level = level_bus[1];
    assign stuck_l   = stuck_bus[0];
    assign stuck_r   = stuck_bus[1];

endmodule
